mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of requester channels (legal 2..4); channel 0 is the FPGA loader port.
REQ-002 SHALL have parameter ADDR_W, default 12, RAM word-address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before abort (legal 1..65535).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req  input  NUM_CH  per-channel request, held high until that channel's ready.
REQ-008 SHALL have port wen  input  NUM_CH  per-channel write (1) / read (0) select.
REQ-009 SHALL have port addr  input  NUM_CH x ADDR_W  per-channel address.
REQ-010 SHALL have port wdata  input  NUM_CH x DATA_W  per-channel write data.
REQ-011 SHALL have port grant  output  NUM_CH  one-hot owner of the current transaction.
REQ-012 SHALL have port ready  output  NUM_CH  one-cycle completion pulse per channel.
REQ-013 SHALL have port rdata  output  DATA_W  read data, valid in the ready cycle, held until next completion.
REQ-014 SHALL have port err  output  1  one-cycle pulse coincident with ready when a transaction timed out.
REQ-015 SHALL have ports ram_we output 1, ram_addr output ADDR_W, ram_wdata output DATA_W: RAM command.
REQ-016 SHALL have ports ram_rdata input DATA_W, ram_busy input 1: RAM response.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE: when any req is high, SHALL select the winner by round-robin starting at (last+1) mod NUM_CH, latch its wen/addr/wdata, set grant, move to ISSUE.
REQ-019 ISSUE: SHALL drive ram_addr/ram_wdata from the latch and assert ram_we for exactly this cycle if latched wen=1; next state WAIT.
REQ-020 WAIT: SHALL hold ram_addr/ram_wdata stable; when ram_busy=0, capture ram_rdata (reads only) and move to DONE.
REQ-021 WAIT: SHALL count cycles; at count=TIMEOUT with ram_busy still 1, move to DONE with err flag set and rdata unchanged.
REQ-022 DONE: SHALL pulse ready[owner] (and err if flagged), update last=owner, clear grant, return to IDLE.
REQ-023 Minimum latency SHALL be req high in cycle 0 -> ready in cycle 3 (ram_busy=0 throughout).
REQ-024 Request changes after grant SHALL be ignored; the latched transaction always completes.
REQ-025 A channel whose req stays high after ready SHALL rejoin arbitration no earlier than the following IDLE; with all channels requesting, service order SHALL be 0,1,..,NUM_CH-1,0...
REQ-026 ram_we SHALL never be high outside ISSUE; ram outputs SHALL be 0 in IDLE.

Reset
REQ-027 reset SHALL asynchronously force IDLE, grant=0, ready=0, err=0, rdata=0, ram_we=0, ram_addr=0, ram_wdata=0, WAIT counter=0, last=NUM_CH-1 (so channel 0 wins first).
REQ-028 Reset mid-transaction SHALL abandon it with no ready pulse; the owner re-requests.

Configuration
REQ-029 With macro MEM_ARB_LOCK_EN defined, SHALL add input lock (1 bit): while lock=1, IDLE grants only channel 0, all other requests wait; an in-flight non-0 transaction completes normally.
REQ-030 Without MEM_ARB_LOCK_EN, no lock port SHALL exist and arbitration is pure round-robin.

Verification
REQ-031 NUM_CH=2, reset release, req=2'b11 both reads, ram_busy=0 -> ready[0] at cycle 3, ready[1] at cycle 7, grant sequence 01,10.
REQ-032 Ch1 write addr=12'h0A5 wdata=32'hDEADBEEF -> ram_we high exactly one cycle with those values; ch0 read of 12'h0A5 then returns rdata=32'hDEADBEEF.
REQ-033 TIMEOUT=4, ram_busy stuck 1 -> ready and err pulse together 4 WAIT cycles after ISSUE; FSM returns to IDLE.
REQ-034 reset asserted during WAIT -> all outputs 0 within same cycle, no ready pulse, ch0 wins the next request.
REQ-035 MEM_ARB_LOCK_EN, lock=1, req=4'b1111 (NUM_CH=4) -> only ch0 served repeatedly; lock=0 -> ch1,ch2,ch3 follow in order.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between NUM_CH requesters, with a WAIT timeout.
// Optional: define MEM_ARB_LOCK_EN to add a 'lock' input that reserves the RAM for channel 0.

module mem_arbiter #(
   parameter int NUM_CH  = 2,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     reset,
`ifdef MEM_ARB_LOCK_EN
   input  logic                     lock,
`endif
   input  logic [NUM_CH-1:0]        req,
   input  logic [NUM_CH-1:0]        wen,
   input  logic [NUM_CH*ADDR_W-1:0] addr,
   input  logic [NUM_CH*DATA_W-1:0] wdata,
   output logic [NUM_CH-1:0]        grant,
   output logic [NUM_CH-1:0]        ready,
   output logic [DATA_W-1:0]        rdata,
   output logic                     err,
   output logic                     ram_we,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic [DATA_W-1:0]        ram_wdata,
   input  logic [DATA_W-1:0]        ram_rdata,
   input  logic                     ram_busy
);

   localparam int CH_W = (NUM_CH > 2) ? 2 : 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [CH_W-1:0]     last_q;
   logic [CH_W-1:0]     owner_q;
   logic [CH_W-1:0]     win_idx;
   logic                win_valid;
   logic [NUM_CH-1:0]   win_onehot;
   logic [NUM_CH-1:0]   arb_req;
   logic [NUM_CH-1:0]   grant_q;
   logic                lat_wen;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic [DATA_W-1:0]   rdata_q;
   logic [15:0]         wait_cnt;
   logic                err_q;
   logic                timeout_hit;

   logic [ADDR_W-1:0]   addr_arr  [NUM_CH];
   logic [DATA_W-1:0]   wdata_arr [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
      assign addr_arr[g]  = addr[g*ADDR_W +: ADDR_W];
      assign wdata_arr[g] = wdata[g*DATA_W +: DATA_W];
   end

   // Requests eligible for this arbitration round; lock narrows the field to channel 0.
   always_comb begin
`ifdef MEM_ARB_LOCK_EN
      arb_req = lock ? (req & {{(NUM_CH-1){1'b0}}, 1'b1}) : req;
`else
      arb_req = req;
`endif
   end

   // Search starts just after the previous owner so every channel gets a turn.
   always_comb begin
      int              cand;
      logic [CH_W-1:0] cand_idx;
      cand       = 0;
      cand_idx   = '0;
      win_valid  = 1'b0;
      win_idx    = '0;
      win_onehot = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand = int'(last_q) + i;
         if (cand >= NUM_CH) begin
            cand = cand - NUM_CH;
         end
         cand_idx = CH_W'(cand);
         if (!win_valid && arb_req[cand_idx]) begin
            win_valid = 1'b1;
            win_idx   = cand_idx;
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         win_onehot[i] = win_valid && (CH_W'(i) == win_idx);
      end
   end

   assign timeout_hit = (wait_cnt == 16'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ready     = '0;
      err       = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            ram_we    = lat_wen;
            ram_addr  = lat_addr;
            ram_wdata = lat_wdata;
            state_d   = WAIT;
         end
         WAIT: begin
            ram_addr  = lat_addr;
            ram_wdata = lat_wdata;
            if (!ram_busy || timeout_hit) begin
               state_d = DONE;
            end
         end
         DONE: begin
            ready   = grant_q;
            err     = err_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A response arriving on the final WAIT cycle wins over the timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q    <= CH_W'(NUM_CH - 1);
         owner_q   <= '0;
         grant_q   <= '0;
         lat_wen   <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata_q   <= '0;
         wait_cnt  <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_valid) begin
                  owner_q   <= win_idx;
                  grant_q   <= win_onehot;
                  lat_wen   <= wen[win_idx];
                  lat_addr  <= addr_arr[win_idx];
                  lat_wdata <= wdata_arr[win_idx];
                  err_q     <= 1'b0;
                  wait_cnt  <= '0;
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
            end
            WAIT: begin
               if (!ram_busy) begin
                  if (!lat_wen) begin
                     rdata_q <= ram_rdata;
                  end
               end else if (timeout_hit) begin
                  err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            DONE: begin
               last_q  <= owner_q;
               grant_q <= '0;
               err_q   <= 1'b0;
            end
            default: begin
               grant_q <= '0;
            end
         endcase
      end
   end

   assign grant = grant_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-channel instance (TIMEOUT=4) and a 4-channel instance.
// RAM models store data scrambled with the address so unwritten words read as {20'hABCDE, addr}.

module tb_mem_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   logic [1:0]  req_a, wen_a, grant_a, ready_a;
   logic [23:0] addr_a;
   logic [63:0] wdata_a;
   logic [31:0] rdata_a, ram_wdata_a, ram_rdata_a;
   logic        err_a, ram_we_a, ram_busy_a;
   logic [11:0] ram_addr_a;

   logic [3:0]   req_b, wen_b, grant_b, ready_b;
   logic [47:0]  addr_b;
   logic [127:0] wdata_b;
   logic [31:0]  rdata_b, ram_wdata_b, ram_rdata_b;
   logic         err_b, ram_we_b, ram_busy_b;
   logic [11:0]  ram_addr_b;

`ifdef MEM_ARB_LOCK_EN
   logic lock_a, lock_b;
`endif

   logic [31:0] mem_a [4096] = '{default: 32'h0};
   logic [31:0] mem_b [4096] = '{default: 32'h0};

   always @(posedge clk) if (ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a ^ {20'hABCDE, ram_addr_a};
   always @(posedge clk) if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b ^ {20'hABCDE, ram_addr_b};
   assign ram_rdata_a = mem_a[ram_addr_a] ^ {20'hABCDE, ram_addr_a};
   assign ram_rdata_b = mem_b[ram_addr_b] ^ {20'hABCDE, ram_addr_b};

   mem_arbiter #(.NUM_CH(2), .ADDR_W(12), .DATA_W(32), .TIMEOUT(4)) dut_a (
      .clk(clk), .reset(reset),
`ifdef MEM_ARB_LOCK_EN
      .lock(lock_a),
`endif
      .req(req_a), .wen(wen_a), .addr(addr_a), .wdata(wdata_a),
      .grant(grant_a), .ready(ready_a), .rdata(rdata_a), .err(err_a),
      .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
      .ram_rdata(ram_rdata_a), .ram_busy(ram_busy_a)
   );

   mem_arbiter #(.NUM_CH(4), .ADDR_W(12), .DATA_W(32), .TIMEOUT(255)) dut_b (
      .clk(clk), .reset(reset),
`ifdef MEM_ARB_LOCK_EN
      .lock(lock_b),
`endif
      .req(req_b), .wen(wen_b), .addr(addr_b), .wdata(wdata_b),
      .grant(grant_b), .ready(ready_b), .rdata(rdata_b), .err(err_b),
      .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
      .ram_rdata(ram_rdata_b), .ram_busy(ram_busy_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_a = '0; wen_a = '0; addr_a = '0; wdata_a = '0; ram_busy_a = 1'b0;
      req_b = '0; wen_b = '0; addr_b = '0; wdata_b = '0; ram_busy_b = 1'b0;
`ifdef MEM_ARB_LOCK_EN
      lock_a = 1'b0; lock_b = 1'b0;
`endif
      repeat (2) tick();
      n_checks++;
      if (grant_a !== 2'b00 || ready_a !== 2'b00 || err_a !== 1'b0)
         $display("[TB] FAIL reset_ctl got grant=%b ready=%b err=%b exp 00 00 0", grant_a, ready_a, err_a);
      else n_pass++;
      n_checks++;
      if (rdata_a !== 32'h0) $display("[TB] FAIL reset_rdata got %h exp 0", rdata_a);
      else n_pass++;
      n_checks++;
      if (ram_we_a !== 1'b0 || ram_addr_a !== 12'h0 || ram_wdata_a !== 32'h0)
         $display("[TB] FAIL reset_ram got we=%b addr=%h wdata=%h exp 0", ram_we_a, ram_addr_a, ram_wdata_a);
      else n_pass++;
      n_checks++;
      if (grant_b !== 4'b0 || ready_b !== 4'b0) $display("[TB] FAIL reset_b got grant=%b ready=%b exp 0", grant_b, ready_b);
      else n_pass++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_round_robin2();
      logic [1:0] exp_grant [1:8] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
      logic [1:0] exp_ready [1:8] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
      addr_a = {12'h020, 12'h010};
      wen_a  = 2'b00;
      req_a  = 2'b11;
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_checks++;
         if (grant_a !== exp_grant[k]) $display("[TB] FAIL rr2_grant k=%0d got %b exp %b", k, grant_a, exp_grant[k]);
         else n_pass++;
         n_checks++;
         if (ready_a !== exp_ready[k]) $display("[TB] FAIL rr2_ready k=%0d got %b exp %b", k, ready_a, exp_ready[k]);
         else n_pass++;
         if (k == 3 || k == 7) begin
            n_checks++;
            if (rdata_a !== ((k == 3) ? 32'hABCDE010 : 32'hABCDE020))
               $display("[TB] FAIL rr2_rdata k=%0d got %h", k, rdata_a);
            else n_pass++;
         end
      end
      req_a = 2'b00;
   endtask

   task automatic test_write_read();
      int we_cnt = 0;
      wen_a   = 2'b10;
      addr_a  = {12'h0A5, 12'h000};
      wdata_a = {32'hDEADBEEF, 32'h0};
      req_a   = 2'b10;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (ram_we_a) we_cnt++;
         if (k == 1) begin
            n_checks++;
            if (ram_we_a !== 1'b1 || ram_addr_a !== 12'h0A5 || ram_wdata_a !== 32'hDEADBEEF || grant_a !== 2'b10)
               $display("[TB] FAIL wr_issue got we=%b addr=%h wdata=%h grant=%b exp 1 0a5 deadbeef 10",
                        ram_we_a, ram_addr_a, ram_wdata_a, grant_a);
            else n_pass++;
         end else if (k == 2) begin
            n_checks++;
            if (ram_we_a !== 1'b0 || ram_addr_a !== 12'h0A5 || ram_wdata_a !== 32'hDEADBEEF)
               $display("[TB] FAIL wr_wait got we=%b addr=%h wdata=%h exp 0 0a5 deadbeef", ram_we_a, ram_addr_a, ram_wdata_a);
            else n_pass++;
         end else if (k == 3) begin
            n_checks++;
            if (ready_a !== 2'b10 || rdata_a !== 32'hABCDE020)
               $display("[TB] FAIL wr_done got ready=%b rdata=%h exp 10 abcde020", ready_a, rdata_a);
            else n_pass++;
            req_a = 2'b00;
         end else begin
            n_checks++;
            if (ram_addr_a !== 12'h0 || ram_wdata_a !== 32'h0 || grant_a !== 2'b00)
               $display("[TB] FAIL wr_idle got addr=%h wdata=%h grant=%b exp 0", ram_addr_a, ram_wdata_a, grant_a);
            else n_pass++;
         end
      end
      n_checks++;
      if (we_cnt != 1) $display("[TB] FAIL wr_we_count got %0d exp 1", we_cnt);
      else n_pass++;
      wen_a  = 2'b00;
      addr_a = {12'h000, 12'h0A5};
      req_a  = 2'b01;
      repeat (3) tick();
      n_checks++;
      if (ready_a !== 2'b01 || rdata_a !== 32'hDEADBEEF)
         $display("[TB] FAIL rd_back got ready=%b rdata=%h exp 01 deadbeef", ready_a, rdata_a);
      else n_pass++;
      req_a = 2'b00;
      tick();
   endtask

   task automatic test_timeout();
      ram_busy_a = 1'b1;
      addr_a = {12'h000, 12'h044};
      req_a  = 2'b01;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k <= 5) begin
            n_checks++;
            if (ready_a !== 2'b00 || err_a !== 1'b0)
               $display("[TB] FAIL to_early k=%0d got ready=%b err=%b exp 00 0", k, ready_a, err_a);
            else n_pass++;
         end else if (k == 6) begin
            n_checks++;
            if (ready_a !== 2'b01 || err_a !== 1'b1 || rdata_a !== 32'hDEADBEEF)
               $display("[TB] FAIL to_done got ready=%b err=%b rdata=%h exp 01 1 deadbeef", ready_a, err_a, rdata_a);
            else n_pass++;
            req_a = 2'b00;
         end else begin
            n_checks++;
            if (grant_a !== 2'b00 || err_a !== 1'b0 || ram_addr_a !== 12'h0)
               $display("[TB] FAIL to_idle got grant=%b err=%b addr=%h exp 00 0 0", grant_a, err_a, ram_addr_a);
            else n_pass++;
         end
      end
      addr_a = {12'h033, 12'h000};
      req_a  = 2'b10;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 5) ram_busy_a = 1'b0;
         if (k == 6) begin
            n_checks++;
            if (ready_a !== 2'b10 || err_a !== 1'b0 || rdata_a !== 32'hABCDE033)
               $display("[TB] FAIL to_last_cycle got ready=%b err=%b rdata=%h exp 10 0 abcde033", ready_a, err_a, rdata_a);
            else n_pass++;
            req_a = 2'b00;
         end
      end
      tick();
   endtask

   task automatic test_reset_mid();
      addr_a = {12'h055, 12'h066};
      req_a  = 2'b01;
      repeat (3) tick();
      req_a = 2'b00;
      tick();
      ram_busy_a = 1'b1;
      req_a = 2'b10;
      tick();
      n_checks++;
      if (grant_a !== 2'b10) $display("[TB] FAIL rm_owner got grant=%b exp 10", grant_a);
      else n_pass++;
      tick();
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (grant_a !== 2'b00 || ready_a !== 2'b00 || err_a !== 1'b0 || rdata_a !== 32'h0)
         $display("[TB] FAIL rm_async got grant=%b ready=%b err=%b rdata=%h exp 0", grant_a, ready_a, err_a, rdata_a);
      else n_pass++;
      n_checks++;
      if (ram_we_a !== 1'b0 || ram_addr_a !== 12'h0 || ram_wdata_a !== 32'h0)
         $display("[TB] FAIL rm_ram got we=%b addr=%h wdata=%h exp 0", ram_we_a, ram_addr_a, ram_wdata_a);
      else n_pass++;
      tick();
      reset = 1'b0;
      ram_busy_a = 1'b0;
      req_a = 2'b11;
      for (int k = 1; k <= 3; k++) begin
         tick();
         n_checks++;
         if (ready_a !== ((k == 3) ? 2'b01 : 2'b00) || grant_a !== 2'b01)
            $display("[TB] FAIL rm_after k=%0d got ready=%b grant=%b", k, ready_a, grant_a);
         else n_pass++;
      end
      n_checks++;
      if (rdata_a !== 32'hABCDE066) $display("[TB] FAIL rm_rdata got %h exp abcde066", rdata_a);
      else n_pass++;
      req_a = 2'b00;
      tick();
   endtask

   task automatic test_round_robin4();
      int ch;
      int order2 [2] = '{1, 3};
      addr_b = {12'h303, 12'h202, 12'h101, 12'h000};
      req_b  = 4'b1111;
      for (int k = 1; k <= 20; k++) begin
         tick();
         ch = ((k - 1) / 4) % 4;
         if (k % 4 == 3) begin
            n_checks++;
            if (ready_b !== (4'b0001 << ch) || rdata_b !== {20'hABCDE, 12'(ch * 257)})
               $display("[TB] FAIL rr4_done k=%0d got ready=%b rdata=%h exp ch%0d", k, ready_b, rdata_b, ch);
            else n_pass++;
            if (k == 19) req_b = 4'b0000;
         end else if (k % 4 == 1) begin
            n_checks++;
            if (grant_b !== (4'b0001 << ch) || ready_b !== 4'b0)
               $display("[TB] FAIL rr4_grant k=%0d got grant=%b ready=%b exp ch%0d", k, grant_b, ready_b, ch);
            else n_pass++;
         end
      end
      req_b = 4'b1010;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k % 4 == 3) begin
            n_checks++;
            if (ready_b !== (4'b0001 << order2[k / 4]))
               $display("[TB] FAIL rr4_sparse k=%0d got ready=%b exp ch%0d", k, ready_b, order2[k / 4]);
            else n_pass++;
            if (k == 7) req_b = 4'b0000;
         end
      end
   endtask

`ifdef MEM_ARB_LOCK_EN
   task automatic test_lock();
      int exp_ch [6] = '{0, 0, 0, 1, 2, 3};
      lock_b = 1'b1;
      req_b  = 4'b1111;
      for (int k = 1; k <= 23; k++) begin
         tick();
         if (k % 4 == 3) begin
            n_checks++;
            if (ready_b !== (4'b0001 << exp_ch[k / 4]))
               $display("[TB] FAIL lock_order k=%0d got ready=%b exp ch%0d", k, ready_b, exp_ch[k / 4]);
            else n_pass++;
            if (k == 11) lock_b = 1'b0;
         end
      end
      req_b = 4'b0000;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_round_robin2();
      test_write_read();
      test_timeout();
      test_reset_mid();
      test_round_robin4();
`ifdef MEM_ARB_LOCK_EN
      test_lock();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
